// File: rtl/sound_pkg.sv
// Shared constants for the sound channel controllers: register addresses,
// read masks and the frame-sequencer step decode.
package sound_pkg;

    localparam logic [7:0] NR10_ADDR = 8'h10;
    localparam logic [7:0] NR11_ADDR = 8'h11;
    localparam logic [7:0] NR12_ADDR = 8'h12;
    localparam logic [7:0] NR13_ADDR = 8'h13;
    localparam logic [7:0] NR14_ADDR = 8'h14;

    // Bits forced to 1 on read-back; NR13 is write-only.
    localparam logic [7:0] NR10_RMASK    = 8'h80;
    localparam logic [7:0] NR11_RMASK    = 8'h3F;
    localparam logic [7:0] NR12_RMASK    = 8'h00;
    localparam logic [7:0] NR13_RMASK    = 8'hFF;
    localparam logic [7:0] NR14_RMASK    = 8'hBF;
    localparam logic [7:0] UNMAPPED_READ = 8'hFF;

    // Bit i set means step i issues that tick.
    localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
    localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
    localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

endpackage

// File: rtl/sound_frame_seq.sv
// 512 Hz frame sequencer: prescaler, 3-bit step counter and registered
// one-cycle length / sweep / envelope ticks.
module sound_frame_seq
    import sound_pkg::*;
#(
    parameter int FRAME_DIV = 8192
) (
    input  logic clk,
    input  logic rst_n,
    input  logic apu_en,
    output logic clk_length_ctr,
    output logic clk_sweep,
    output logic clk_vol_env
);

    localparam int PW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [PW-1:0] presc;
    logic [2:0]    step;
    logic [2:0]    step_nxt;
    logic          wrap;
    logic          len_q;
    logic          sweep_q;
    logic          env_q;

    assign wrap     = (presc == PW'(FRAME_DIV - 1));
    assign step_nxt = step + 3'd1;

    // Ticks are decoded from the step value being entered on the wrap edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            step    <= '0;
            len_q   <= 1'b0;
            sweep_q <= 1'b0;
            env_q   <= 1'b0;
        end else if (!apu_en) begin
            presc   <= '0;
            step    <= '0;
            len_q   <= 1'b0;
            sweep_q <= 1'b0;
            env_q   <= 1'b0;
        end else begin
            presc   <= wrap ? '0 : presc + PW'(1);
            if (wrap) step <= step_nxt;
            len_q   <= wrap & LEN_STEPS[step_nxt];
            sweep_q <= wrap & SWEEP_STEPS[step_nxt];
            env_q   <= wrap & ENV_STEPS[step_nxt];
        end
    end

    assign clk_length_ctr = len_q & apu_en;
    assign clk_sweep      = sweep_q & apu_en;
    assign clk_vol_env    = env_q & apu_en;

endmodule

// File: rtl/sound_square_ctrl.sv
// Square/sweep tone channel controller: NR10-NR14 register file, masked
// read-back, retrigger pulse generator and frame-sequencer instance.
module sound_square_ctrl
    import sound_pkg::*;
#(
    parameter int FRAME_DIV = 8192,
    parameter int START_LEN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        apu_en,
    input  logic [7:0]  addr,
    input  logic        wr,
    input  logic        rd,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic [2:0]  sweep_time,
    output logic        sweep_decreasing,
    output logic [2:0]  num_sweep_shifts,
    output logic [1:0]  wave_duty,
    output logic [5:0]  length,
    output logic [3:0]  initial_volume,
    output logic        envelope_increasing,
    output logic [2:0]  num_envelope_sweeps,
    output logic [10:0] frequency,
    output logic        single,
    output logic        start,
    output logic        clk_length_ctr,
    output logic        clk_sweep,
    output logic        clk_vol_env
);

    localparam int SW = $clog2(START_LEN + 1);

    logic [6:0]    nr10;
    logic [7:0]    nr11;
    logic [7:0]    nr12;
    logic [7:0]    nr13;
    logic          nr14_single;
    logic [2:0]    nr14_freq_hi;
    logic [SW-1:0] start_cnt;
    logic          trigger;
    logic [7:0]    rd_val;

    assign trigger = wr & apu_en & (addr == NR14_ADDR) & din[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nr10         <= '0;
            nr11         <= '0;
            nr12         <= '0;
            nr13         <= '0;
            nr14_single  <= 1'b0;
            nr14_freq_hi <= '0;
        end else if (!apu_en) begin
            nr10         <= '0;
            nr11         <= '0;
            nr12         <= '0;
            nr13         <= '0;
            nr14_single  <= 1'b0;
            nr14_freq_hi <= '0;
        end else if (wr) begin
            case (addr)
                NR10_ADDR: nr10 <= din[6:0];
                NR11_ADDR: nr11 <= din;
                NR12_ADDR: nr12 <= din;
                NR13_ADDR: nr13 <= din;
                NR14_ADDR: begin
                    nr14_single  <= din[6];
                    nr14_freq_hi <= din[2:0];
                end
                default: ;
            endcase
        end
    end

    // A trigger during an active pulse reloads the counter, stretching the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_cnt <= '0;
        end else if (!apu_en) begin
            start_cnt <= '0;
        end else if (trigger) begin
            start_cnt <= SW'(START_LEN);
        end else if (start_cnt != '0) begin
            start_cnt <= start_cnt - SW'(1);
        end
    end

    assign start = (start_cnt != '0) & apu_en;

    // Registers are gated by apu_en so reads in the disabling cycle already see zero.
    always_comb begin
        rd_val = UNMAPPED_READ;
        case (addr)
            NR10_ADDR: rd_val = ({1'b0, nr10} & {8{apu_en}}) | NR10_RMASK;
            NR11_ADDR: rd_val = (nr11 & {8{apu_en}}) | NR11_RMASK;
            NR12_ADDR: rd_val = (nr12 & {8{apu_en}}) | NR12_RMASK;
            NR13_ADDR: rd_val = (nr13 & {8{apu_en}}) | NR13_RMASK;
            NR14_ADDR: rd_val = ({1'b0, nr14_single, 3'b000, nr14_freq_hi} & {8{apu_en}})
                                | NR14_RMASK;
            default:   rd_val = UNMAPPED_READ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (rd) begin
            dout <= rd_val;
        end
    end

    assign sweep_time          = nr10[6:4];
    assign sweep_decreasing    = nr10[3];
    assign num_sweep_shifts    = nr10[2:0];
    assign wave_duty           = nr11[7:6];
    assign length              = nr11[5:0];
    assign initial_volume      = nr12[7:4];
    assign envelope_increasing = nr12[3];
    assign num_envelope_sweeps = nr12[2:0];
    assign frequency           = {nr14_freq_hi, nr13};
    assign single              = nr14_single;

    sound_frame_seq #(
        .FRAME_DIV(FRAME_DIV)
    ) u_frame_seq (
        .clk            (clk),
        .rst_n          (rst_n),
        .apu_en         (apu_en),
        .clk_length_ctr (clk_length_ctr),
        .clk_sweep      (clk_sweep),
        .clk_vol_env    (clk_vol_env)
    );

endmodule

// File: tb/tb_sound_square_ctrl.sv
// Bench for sound_square_ctrl: register table, read scoreboard, trigger
// pulses, frame-sequencer tick schedule, apu_en gating and async reset.
module tb_sound_square_ctrl;
    import sound_pkg::*;

    localparam int FD = 32;
    localparam int SL = 2;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        apu_en = 1'b1;
    logic [7:0]  addr   = 8'h00;
    logic        wr     = 1'b0;
    logic        rd     = 1'b0;
    logic [7:0]  din    = 8'h00;
    logic [7:0]  dout;
    logic [2:0]  sweep_time;
    logic        sweep_decreasing;
    logic [2:0]  num_sweep_shifts;
    logic [1:0]  wave_duty;
    logic [5:0]  length;
    logic [3:0]  initial_volume;
    logic        envelope_increasing;
    logic [2:0]  num_envelope_sweeps;
    logic [10:0] frequency;
    logic        single;
    logic        start;
    logic        clk_length_ctr;
    logic        clk_sweep;
    logic        clk_vol_env;

    sound_square_ctrl #(
        .FRAME_DIV(FD),
        .START_LEN(SL)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .apu_en              (apu_en),
        .addr                (addr),
        .wr                  (wr),
        .rd                  (rd),
        .din                 (din),
        .dout                (dout),
        .sweep_time          (sweep_time),
        .sweep_decreasing    (sweep_decreasing),
        .num_sweep_shifts    (num_sweep_shifts),
        .wave_duty           (wave_duty),
        .length              (length),
        .initial_volume      (initial_volume),
        .envelope_increasing (envelope_increasing),
        .num_envelope_sweeps (num_envelope_sweeps),
        .frequency           (frequency),
        .single              (single),
        .start               (start),
        .clk_length_ctr      (clk_length_ctr),
        .clk_sweep           (clk_sweep),
        .clk_vol_env         (clk_vol_env)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] waddr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] all_out();
        return {17'd0, dout, sweep_time, sweep_decreasing, num_sweep_shifts, wave_duty,
                length, initial_volume, envelope_increasing, num_envelope_sweeps,
                frequency, single, start, clk_length_ctr, clk_sweep, clk_vol_env};
    endfunction

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        addr = a;
        din  = d;
        wr   = 1'b1;
        cyc();
        wr   = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [7:0] a, input logic [7:0] e);
        logic [7:0] x;
        addr = a;
        rd   = 1'b1;
        exp_q.push_back(e);
        cyc();
        rd   = 1'b0;
        x    = exp_q.pop_front();
        chk(name, dout, x);
    endtask

    initial begin
        int   hi_cnt;
        int   len_cnt;
        int   sw_cnt;
        int   env_cnt;
        int   s;
        logic seen_low;
        logic gap;
        logic wrap_c;
        logic e_len;
        logic e_sw;
        logic e_env;

        vecs[0] = '{8'h10, 8'hFF, 8'hFF};
        vecs[1] = '{8'h10, 8'h35, 8'hB5};
        vecs[2] = '{8'h11, 8'hC7, 8'hFF};
        vecs[3] = '{8'h11, 8'h41, 8'h7F};
        vecs[4] = '{8'h12, 8'hA5, 8'hA5};
        vecs[5] = '{8'h13, 8'h12, 8'hFF};
        vecs[6] = '{8'h14, 8'h45, 8'hFF};
        vecs[7] = '{8'h14, 8'h05, 8'hBF};
        vecs[8] = '{8'h15, 8'h00, 8'hFF};
        vecs[9] = '{8'h0F, 8'h5A, 8'hFF};

        // reset release and reset-value reads
        #20 rst_n = 1'b1;
        cyc();
        chk("reset_outputs", all_out(), 64'd0);
        do_read("rst_nr10", NR10_ADDR, 8'h80);
        do_read("rst_nr11", NR11_ADDR, 8'h3F);
        do_read("rst_nr12", NR12_ADDR, 8'h00);
        do_read("rst_nr13", NR13_ADDR, 8'hFF);
        do_read("rst_nr14", NR14_ADDR, 8'hBF);
        do_read("rst_unmapped", 8'h15, 8'hFF);

        // register table: write then read back
        for (int i = 0; i < 10; i++) begin
            do_write(vecs[i].waddr, vecs[i].wdata);
            do_read($sformatf("table_rd[%0d]", i), vecs[i].waddr, vecs[i].exp_rd);
        end
        chk("cfg_sweep_time", sweep_time, 3'd3);
        chk("cfg_sweep_dec", sweep_decreasing, 1'b0);
        chk("cfg_sweep_shifts", num_sweep_shifts, 3'd5);
        chk("cfg_duty", wave_duty, 2'd1);
        chk("cfg_length", length, 6'd1);
        chk("cfg_volume", initial_volume, 4'hA);
        chk("cfg_env_inc", envelope_increasing, 1'b0);
        chk("cfg_env_sweeps", num_envelope_sweeps, 3'd5);
        chk("cfg_frequency", frequency, 11'h512);
        chk("cfg_single", single, 1'b0);
        chk("no_trigger_start", start, 1'b0);

        // simultaneous wr and rd return the old value
        addr = NR12_ADDR;
        din  = 8'h11;
        wr   = 1'b1;
        rd   = 1'b1;
        exp_q.push_back(8'hA5);
        cyc();
        wr   = 1'b0;
        rd   = 1'b0;
        chk("wr_rd_same_old", dout, exp_q.pop_front());
        do_read("wr_rd_same_new", NR12_ADDR, 8'h11);

        // trigger: frequency 0x734, start high exactly START_LEN cycles
        do_write(NR13_ADDR, 8'h34);
        do_write(NR14_ADDR, 8'h87);
        chk("trig_frequency", frequency, 11'h734);
        chk("trig_single", single, 1'b0);
        chk("trig_start_first", start, 1'b1);
        hi_cnt = 1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (start) hi_cnt++;
        end
        chk("trig_start_len", hi_cnt, SL);

        // retrigger one cycle later: 3 contiguous high cycles
        do_write(NR14_ADDR, 8'h80);
        chk("retrig_first", start, 1'b1);
        do_write(NR14_ADDR, 8'h80);
        chk("retrig_second", start, 1'b1);
        hi_cnt   = 2;
        seen_low = 1'b0;
        gap      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (start) begin
                hi_cnt++;
                if (seen_low) gap = 1'b1;
            end else begin
                seen_low = 1'b1;
            end
        end
        chk("retrig_len", hi_cnt, 3);
        chk("retrig_gap", gap, 1'b0);

        // apu_en low mid-frame: cleared registers, ignored writes, no ticks
        for (int i = 0; i < FD / 2; i++) cyc();
        apu_en = 1'b0;
        cyc();
        chk("off_frequency", frequency, 11'h000);
        chk("off_length", length, 6'd0);
        do_write(NR12_ADDR, 8'hF3);
        chk("off_volume", initial_volume, 4'h0);
        do_read("off_nr12", NR12_ADDR, 8'h00);
        do_read("off_nr11", NR11_ADDR, 8'h3F);
        do_write(NR14_ADDR, 8'h80);
        hi_cnt = 0;
        for (int i = 0; i < 3 * FD; i++) begin
            if (start | clk_length_ctr | clk_sweep | clk_vol_env) hi_cnt++;
            cyc();
        end
        chk("off_no_activity", hi_cnt, 0);

        // apu_en rise: full 8-step frame schedule, trigger coinciding with step 2
        apu_en  = 1'b1;
        len_cnt = 0;
        sw_cnt  = 0;
        env_cnt = 0;
        for (int c = 1; c <= 8 * FD + 2; c++) begin
            if (c == 2 * FD) begin
                addr = NR14_ADDR;
                din  = 8'h80;
                wr   = 1'b1;
            end
            cyc();
            wr     = 1'b0;
            wrap_c = ((c % FD) == 0);
            s      = (c / FD) % 8;
            e_len  = wrap_c && ((s % 2) == 0);
            e_sw   = wrap_c && (s == 2 || s == 6);
            e_env  = wrap_c && (s == 7);
            chk($sformatf("len_tick c=%0d", c), clk_length_ctr, e_len);
            chk($sformatf("sweep_tick c=%0d", c), clk_sweep, e_sw);
            chk($sformatf("env_tick c=%0d", c), clk_vol_env, e_env);
            if (c == 2 * FD) chk("trigger_with_tick", start, 1'b1);
            if (clk_length_ctr) len_cnt++;
            if (clk_sweep) sw_cnt++;
            if (clk_vol_env) env_cnt++;
        end
        chk("len_tick_count", len_cnt, 4);
        chk("sweep_tick_count", sw_cnt, 2);
        chk("env_tick_count", env_cnt, 1);

        // async reset mid-pulse
        do_read("pre_reset_rd", NR11_ADDR, 8'h3F);
        do_write(NR14_ADDR, 8'h80);
        chk("pre_reset_start", start, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_start", start, 1'b0);
        chk("async_reset_outputs", all_out(), 64'd0);
        #10 rst_n = 1'b1;
        cyc();
        chk("post_reset_outputs", all_out(), 64'd0);
        do_read("post_reset_nr10", NR10_ADDR, 8'h80);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sound_square_ctrl.md
# sound_square_ctrl

Register-file and sequencing controller for a square-wave tone channel with sweep. Decodes CPU writes and reads to the five channel registers NR10–NR14 (low address bytes 0x10–0x14). Drives the channel's static configuration inputs. Generates a clean, registered retrigger pulse, and runs the 512 Hz frame sequencer that produces the length, envelope and sweep ticks.

## Interface
Parameters:
- FRAME_DIV, 8192: `clk` cycles per frame-sequencer step (4.194304 MHz / 512 Hz).
- START_LEN, 2: `clk` cycles that `start` stays high per trigger.

Ports:
- clk  in  1  CPU clock; every register in the block is clocked on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- apu_en  in  1  master sound enable (NR52 bit 7).
- addr  in  8  low byte of the I/O address.
- wr  in  1  write strobe, one cycle.
- rd  in  1  read strobe, one cycle.
- din  in  8  write data.
- dout  out  8  read data, registered.
- sweep_time  out  3  NR10[6:4].
- sweep_decreasing  out  1  NR10[3].
- num_sweep_shifts  out  3  NR10[2:0].
- wave_duty  out  2  NR11[7:6].
- length  out  6  NR11[5:0].
- initial_volume  out  4  NR12[7:4].
- envelope_increasing  out  1  NR12[3].
- num_envelope_sweeps  out  3  NR12[2:0].
- frequency  out  11  {NR14[2:0], NR13}.
- single  out  1  NR14[6].
- start  out  1  trigger pulse, START_LEN cycles.
- clk_length_ctr  out  1  length tick, one cycle high, 256 Hz.
- clk_sweep  out  1  sweep tick, one cycle high, 128 Hz.
- clk_vol_env  out  1  envelope tick, one cycle high, 64 Hz.

## Operation
Register writes:
- Writes take effect only when `wr` is high, `addr` is in 0x10–0x14, and `apu_en` is high.
- NR10 stores din[6:0]. NR11 stores all 8 bits. NR12 stores all 8 bits. NR13 stores all 8 bits. NR14 stores din[6] and din[2:0].
- Writing NR14 with din[7]=1 is a trigger. It loads the start counter with START_LEN.
- `start` is high while the start counter is non-zero. The counter decrements each cycle.
- A trigger while `start` is already high reloads the counter, so the pulse is extended, not doubled.
- Configuration outputs update on the same edge that captures the trigger. The channel therefore sees the new frequency and length before or at the rising edge of `start`.

Register reads:
- On `rd`, `dout` is loaded with the register value OR'd with its read mask. Otherwise `dout` holds.
- Read masks: NR10 0x80; NR11 0x3F; NR12 0x00; NR13 0xFF (write-only); NR14 0xBF.
- Any unmapped address reads 0xFF.

Frame sequencer:
- A prescaler counts 0..FRAME_DIV-1. When it wraps, the 3-bit step counter increments, wrapping 7→0.
- On the wrap cycle, the ticks are decoded from the new step value:
  - length tick on steps 0, 2, 4, 6;
  - sweep tick on steps 2, 6;
  - envelope tick on step 7.
- Each tick output is high for exactly one `clk` cycle.

apu_en low:
- All NR registers are cleared to 0.
- The prescaler and step counter are held at 0.
- All ticks and `start` are forced low.
- `dout` still answers reads, using the masked zero values.
- When `apu_en` rises, the prescaler starts from 0 and the first wrap produces step 1.

## Timing
- Reset: every output is 0, including `dout`. The step counter and prescaler are also 0.
- Reset asserted mid-pulse ends `start` immediately (asynchronously).
- Write latency: a write sampled at edge N appears on the configuration outputs after edge N.
- Trigger timing: for a trigger sampled at edge N, `start` is high from edge N to edge N+START_LEN.
- Read latency: a read sampled at edge N is valid on `dout` after edge N and holds until the next read.
- A simultaneous `wr` and `rd` to the same address returns the old value.
- A write and a prescaler wrap in the same cycle both take effect, independently.
- A trigger and a tick in the same cycle are both emitted.
- Tick period at default FRAME_DIV:
  - length tick every 16384 cycles;
  - sweep tick every 32768 cycles;
  - envelope tick every 65536 cycles.

## Structure
- Shared package `sound_pkg` holds:
  - the address constants NR10_ADDR..NR14_ADDR;
  - the read-mask constants;
  - the step-decode constants for which steps issue length, sweep and envelope ticks.
- One sub-module, `sound_frame_seq`. It contains the prescaler, step counter and tick decode, and has inputs `clk`, `rst_n` and `apu_en`. Other channel controllers reuse it.
- The top level holds the register file, read mux and start counter.

## Test plan
- Reset release, then read 0x10–0x14 and 0x15 → 0x80, 0x3F, 0x00, 0xFF, 0xBF, 0xFF.
- Write NR13=0x34, then NR14=0x87 → `frequency`=0x734, `single`=0, `start` high for exactly 2 cycles starting the cycle after the NR14 write.
- Run 8×FRAME_DIV cycles → length ticks at steps 0, 2, 4, 6; sweep ticks at steps 2, 6; one envelope tick at step 7; every tick exactly 1 cycle wide.
- Retrigger NR14 one cycle after a first trigger → `start` stays high for 3 contiguous cycles, with no low gap.
- Drop `apu_en` mid-frame, then write NR12=0xF3 → the write is ignored, NR12 reads 0x00, no ticks occur; after `apu_en` rises, the first tick arrives after FRAME_DIV cycles at step 1, which carries no tick; the first length tick is at step 2.
- Assert `rst_n` low while `start` is high → `start` drops without waiting for a clock edge; all outputs read 0 after release.
